multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore-FSM control unit that sequences a shared-memory multicycle ARM datapath, one instruction over 3-5 states.
//  Decodes Instr[31:12] and holds the NZCV flag register.
//  Evaluates condition codes and drives all datapath enables and muxes.
//  Waits on a memory ready handshake for fetch, load and store.
// PARAMETERS
//  HANDSHAKE   1        1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
//  FLAG_RST    4'b0000  NZCV value loaded on reset
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  reset       in   1   synchronous, active-low reset
//  Instr       in   20  Instr[31:12]: Cond[31:28] Op[27:26] Funct[25:20] Rd[15:12]
//  ALUFlags    in   4   {N,Z,C,V} from ALU, valid in EXECUTER/EXECUTEI
//  mem_ready   in   1   memory completes the current access this cycle
//  mem_req     out  1   high in FETCH, MEMREAD, MEMWRITE
//  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA   out 1 each
//  RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl          out 2 each
//  state       out  4   current state (debug)
//  instr_done  out  1   1-cycle pulse in the final state of each instruction
//  illegal     out  1   1-cycle pulse in DECODE on unsupported encoding
// BEHAVIOUR
//  Reset (reset==0 at edge): state<=FETCH(0), NZCV<=FLAG_RST. Outputs are combinational from state.
//    While reset==0, all write enables, mem_req, instr_done and illegal are forced 0.
//  States: FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXECUTER6 EXECUTEI7 ALUWB8 BRANCH9. Other codes go to FETCH.
//  FETCH:
//    AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
//    IRWrite=PCWrite=mem_ready. Stays in FETCH while !mem_ready, else goes to DECODE.
//  DECODE:
//    ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
//    Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI.
//    Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> illegal=1, next FETCH.
//  MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00. Funct[0]=1 -> MEMREAD, else MEMWRITE.
//  MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready, then goes to MEMWB.
//  MEMWB: ResultSrc=01, RegW=1, instr_done=1, then FETCH.
//  MEMWRITE:
//    AdrSrc=1, MemWrite=CondEx, held high until mem_ready.
//    instr_done=mem_ready. Goes to FETCH on mem_ready.
//  EXECUTER/EXECUTEI:
//    ALUSrcA=0, ALUSrcB=00/01, ALUControl from Funct[4:1] (see below), then ALUWB.
//  ALUWB: ResultSrc=00, RegW=1, instr_done=1, then FETCH.
//  BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx, instr_done=1, then FETCH.
//  RegSrc={Op==01, Op==10}; ImmSrc=Op; both valid in every state.
//  ALUControl decode: cmd 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11.
//    Any other cmd is flagged illegal in DECODE and goes to FETCH with no writes.
//  Register writeback: in MEMWB/ALUWB, if Rd==4'hF then PCWrite=CondEx and RegWrite=0.
//    Otherwise RegWrite=CondEx.
//  Condition evaluation:
//    CondEx is combinational from Cond and the stored NZCV.
//    Supported: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL; 4'hF is treated as AL.
//  Flag update:
//    Only in EXECUTER/EXECUTEI, when Funct[0] (S)=1 and CondEx.
//    N,Z always updated. C,V updated only for ADD/SUB.
//    A flag update made by an instruction is visible to the next instruction's CondEx.
//  CondEx=0 suppresses RegWrite, MemWrite, branch/PC writes and the flag update.
//    The state sequence still runs; instr_done still pulses.
//  Latency with mem_ready=1: DP 4 cycles, LDR 5, STR 4, B 3. Each mem_ready=0 cycle adds 1.
//  Reset during any state: the next state is FETCH. An in-flight store is abandoned (MemWrite=0).
// TESTING
//  1. reset=0 for 2 cycles, then 1, mem_ready=1, ADD R1 (E0811002):
//     state 0,1,6,8,0; RegWrite=1 only in ALUWB; instr_done once.
//  2. LDR (E5912004), mem_ready low 3 cycles in MEMREAD:
//     MEMREAD held 4 cycles with AdrSrc=1; total 8 cycles; RegWrite in MEMWB.
//  3. SUBS (E0520003) with ALUFlags=0110, then BEQ (0A000002):
//     NZCV=0110; BRANCH asserts PCWrite=1.
//  4. BNE (1A000002) with Z=1:
//     states 0,1,9; PCWrite=0 in BRANCH; instr_done=1.
//  5. STR (E5812000), reset=0 in MEMWRITE:
//     MemWrite drops to 0 in the reset cycle; state=FETCH on the next cycle.
//  6. Op=11 (EC000000) and ADD to Rd=15 (E08FF002):
//     illegal pulse then FETCH; for Rd=15, PCWrite=1 and RegWrite=0 in ALUWB.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath/memory bundle for the multicycle ARM core.
//   master : the control unit (consumes instruction fields, flags and
//            mem_ready; drives every enable, mux select and status pulse)
//   slave  : the datapath/memory side
// Instr carries instruction bits [31:12]:
//   Cond=[19:16] Op=[15:14] Funct=[13:8] Rd=[3:0]
interface multicycle_ctrl_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic        mem_req;
  logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl;
  logic [3:0]  state;
  logic        instr_done;
  logic        illegal;

  modport master (
    input  Instr, ALUFlags, mem_ready,
    output mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl,
           state, instr_done, illegal
  );

  modport slave (
    output Instr, ALUFlags, mem_ready,
    input  mem_req, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
           RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl,
           state, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a shared-memory multicycle ARM datapath.
// Sequences each instruction through 3-5 states, holds the NZCV flags,
// evaluates the condition field and drives all datapath enables/muxes.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-low
//   bus   - multicycle_ctrl_if.master (instruction fields, ALU flags,
//           memory handshake, control outputs, debug state, pulses)
// Parameters:
//   HANDSHAKE - 1: memory states wait on mem_ready; 0: mem_ready ignored
//   FLAG_RST  - NZCV value after reset
module multicycle_ctrl #(
  parameter int         HANDSHAKE = 1,
  parameter logic [3:0] FLAG_RST  = 4'b0000
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0, DECODE   = 4'd1, MEMADR   = 4'd2, MEMREAD = 4'd3,
    MEMWB    = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7,
    ALUWB    = 4'd8, BRANCH   = 4'd9
  } state_t;

  state_t     st, st_nxt;
  logic [3:0] nzcv;

  logic [3:0] cond, rd, cmd;
  logic [1:0] op;
  logic [5:0] funct;
  assign cond  = bus.Instr[19:16];
  assign op    = bus.Instr[15:14];
  assign funct = bus.Instr[13:8];
  assign rd    = bus.Instr[3:0];
  assign cmd   = funct[4:1];

  // Rn is decoded by the datapath, not here
  logic unused_rn;
  assign unused_rn = &{1'b0, bus.Instr[7:4]};

  logic rdy;
  assign rdy = (HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  // Supported data-processing commands and their ALU encodings
  logic       cmd_ok, cmd_arith;
  logic [1:0] alu_dec;
  always_comb begin
    cmd_ok    = 1'b1;
    cmd_arith = 1'b0;
    alu_dec   = 2'b00;
    case (cmd)
      4'b0100: begin alu_dec = 2'b00; cmd_arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; cmd_arith = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: cmd_ok = 1'b0;
    endcase
  end

  logic n, z, c, v, cond_ex;
  assign {n, z, c, v} = nzcv;
  always_comb begin
    case (cond)
      4'h0:    cond_ex = z;
      4'h1:    cond_ex = ~z;
      4'h2:    cond_ex = c;
      4'h3:    cond_ex = ~c;
      4'h4:    cond_ex = n;
      4'h5:    cond_ex = ~n;
      4'h6:    cond_ex = v;
      4'h7:    cond_ex = ~v;
      4'h8:    cond_ex = c & ~z;
      4'h9:    cond_ex = ~c | z;
      4'hA:    cond_ex = (n == v);
      4'hB:    cond_ex = (n != v);
      4'hC:    cond_ex = ~z & (n == v);
      4'hD:    cond_ex = z | (n != v);
      default: cond_ex = 1'b1;  // AL, and 4'hF treated as AL
    endcase
  end

  logic dec_illegal;
  assign dec_illegal = (op == 2'b11) || ((op == 2'b00) && !cmd_ok);

  always_ff @(posedge clk) begin
    if (!reset) begin
      st   <= FETCH;
      nzcv <= FLAG_RST;
    end else begin
      st <= st_nxt;
      // C,V only come from the adder; logic ops leave them alone
      if ((st == EXECUTER || st == EXECUTEI) && funct[0] && cond_ex) begin
        nzcv[3:2] <= bus.ALUFlags[3:2];
        if (cmd_arith) nzcv[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    st_nxt         = FETCH;
    bus.PCWrite    = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = 2'b00;
    bus.mem_req    = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;
    case (st)
      FETCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.mem_req   = 1'b1;
        bus.IRWrite   = rdy;
        bus.PCWrite   = rdy;
        st_nxt        = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.illegal   = dec_illegal;
        if (dec_illegal)       st_nxt = FETCH;
        else if (op == 2'b00)  st_nxt = funct[5] ? EXECUTEI : EXECUTER;
        else if (op == 2'b01)  st_nxt = MEMADR;
        else                   st_nxt = BRANCH;
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
        st_nxt      = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc  = 1'b1;
        bus.mem_req = 1'b1;
        st_nxt      = rdy ? MEMWB : MEMREAD;
      end
      MEMWRITE: begin
        bus.AdrSrc     = 1'b1;
        bus.mem_req    = 1'b1;
        bus.MemWrite   = cond_ex;
        bus.instr_done = rdy;
        st_nxt         = rdy ? FETCH : MEMWRITE;
      end
      EXECUTER, EXECUTEI: begin
        bus.ALUSrcB    = (st == EXECUTEI) ? 2'b01 : 2'b00;
        bus.ALUControl = alu_dec;
        st_nxt         = ALUWB;
      end
      MEMWB, ALUWB: begin
        bus.ResultSrc  = (st == MEMWB) ? 2'b01 : 2'b00;
        bus.instr_done = 1'b1;
        // Writes to R15 redirect the PC instead of the register file
        if (rd == 4'hF) bus.PCWrite  = cond_ex;
        else            bus.RegWrite = cond_ex;
      end
      BRANCH: begin
        bus.ALUSrcB    = 2'b01;
        bus.ResultSrc  = 2'b10;
        bus.PCWrite    = cond_ex;
        bus.instr_done = 1'b1;
      end
      default: st_nxt = FETCH;
    endcase
    // Reset abandons whatever is in flight, including a pending store
    if (!reset) begin
      bus.PCWrite    = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.mem_req    = 1'b0;
      bus.instr_done = 1'b0;
      bus.illegal    = 1'b0;
    end
  end

  assign bus.RegSrc = {op == 2'b01, op == 2'b10};
  assign bus.ImmSrc = op;
  assign bus.state  = st;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();
  multicycle_ctrl #(.HANDSHAKE(1), .FLAG_RST(4'b0000)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    string       nm;
    logic [15:0] v;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, mem_req,
  //  instr_done, illegal, ALUSrcB, ALUControl}
  function automatic logic [15:0] E(input logic [3:0] st, input logic pcw,
      input logic irw, input logic rw, input logic mw, input logic adr,
      input logic mreq, input logic done, input logic ill,
      input logic [1:0] srcb, input logic [1:0] aluc);
    return {st, pcw, irw, rw, mw, adr, mreq, done, ill, srcb, aluc};
  endfunction

  // Drive one cycle's inputs just after the edge and queue what the
  // outputs must look like during that cycle.
  task automatic cyc(input logic r, input logic rdy, input logic [19:0] ins,
                     input logic [3:0] fl, input string nm,
                     input logic [15:0] ev);
    exp_t e;
    @(posedge clk); #1;
    reset         = r;
    bus.mem_ready = rdy;
    bus.Instr     = ins;
    bus.ALUFlags  = fl;
    e.nm = nm;
    e.v  = ev;
    q.push_back(e);
  endtask

  // Monitor: one expected record per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = q.pop_front();
      act = {bus.state, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
             bus.AdrSrc, bus.mem_req, bus.instr_done, bus.illegal,
             bus.ALUSrcB, bus.ALUControl};
      n_chk++;
      if (act === e.v) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
    end
  end

  localparam logic [19:0] ADD   = 20'hE0811;  // ADD R1
  localparam logic [19:0] LDR   = 20'hE5912;
  localparam logic [19:0] SUBS  = 20'hE0520;
  localparam logic [19:0] BEQ   = 20'h0A000;
  localparam logic [19:0] BNE   = 20'h1A000;
  localparam logic [19:0] ADDNE = 20'h10811;
  localparam logic [19:0] STR   = 20'hE5812;
  localparam logic [19:0] OP11  = 20'hEC000;
  localparam logic [19:0] EOR   = 20'hE0211;  // cmd 0001: unsupported
  localparam logic [19:0] ADDPC = 20'hE08FF;  // ADD R15

  initial begin
    reset = 1'b0; bus.mem_ready = 1'b1; bus.Instr = '0; bus.ALUFlags = '0;
    @(posedge clk);
    // reset held: FETCH with every enable/pulse masked
    cyc(0, 1, ADD, 4'h0, "rst0", E(0,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(0, 1, ADD, 4'h0, "rst1", E(0,0,0,0,0,0,0,0,0,2'b10,2'b00));
    // ADD: 0,1,6,8
    cyc(1, 1, ADD, 4'h0, "add_f",  E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, ADD, 4'h0, "add_d",  E(1,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(1, 1, ADD, 4'h0, "add_x",  E(6,0,0,0,0,0,0,0,0,2'b00,2'b00));
    cyc(1, 1, ADD, 4'h0, "add_wb", E(8,0,0,1,0,0,0,1,0,2'b00,2'b00));
    // LDR with 3 stall cycles in MEMREAD: 8 cycles total
    cyc(1, 1, LDR, 4'h0, "ldr_f",  E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, LDR, 4'h0, "ldr_d",  E(1,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(1, 1, LDR, 4'h0, "ldr_ma", E(2,0,0,0,0,0,0,0,0,2'b01,2'b00));
    for (int i = 0; i < 3; i++)
      cyc(1, 0, LDR, 4'h0, "ldr_rd_wait", E(3,0,0,0,0,1,1,0,0,2'b00,2'b00));
    cyc(1, 1, LDR, 4'h0, "ldr_rd", E(3,0,0,0,0,1,1,0,0,2'b00,2'b00));
    cyc(1, 1, LDR, 4'h0, "ldr_wb", E(4,0,0,1,0,0,0,1,0,2'b00,2'b00));
    // SUBS sets NZCV=0110 (Z=1)
    cyc(1, 1, SUBS, 4'h0, "subs_f",  E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, SUBS, 4'h0, "subs_d",  E(1,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(1, 1, SUBS, 4'h6, "subs_x",  E(6,0,0,0,0,0,0,0,0,2'b00,2'b01));
    cyc(1, 1, SUBS, 4'h0, "subs_wb", E(8,0,0,1,0,0,0,1,0,2'b00,2'b00));
    // BEQ taken
    cyc(1, 1, BEQ, 4'h0, "beq_f",  E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, BEQ, 4'h0, "beq_d",  E(1,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(1, 1, BEQ, 4'h0, "beq_br", E(9,1,0,0,0,0,0,1,0,2'b01,2'b00));
    // BNE not taken, with one fetch stall
    cyc(1, 0, BNE, 4'h0, "bne_fw", E(0,0,0,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, BNE, 4'h0, "bne_f",  E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, BNE, 4'h0, "bne_d",  E(1,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(1, 1, BNE, 4'h0, "bne_br", E(9,0,0,0,0,0,0,1,0,2'b01,2'b00));
    // ADDNE with Z=1: no register write, still completes
    cyc(1, 1, ADDNE, 4'h0, "addne_f",  E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, ADDNE, 4'h0, "addne_d",  E(1,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(1, 1, ADDNE, 4'h0, "addne_x",  E(6,0,0,0,0,0,0,0,0,2'b00,2'b00));
    cyc(1, 1, ADDNE, 4'h0, "addne_wb", E(8,0,0,0,0,0,0,1,0,2'b00,2'b00));
    // STR interrupted by reset in MEMWRITE
    cyc(1, 1, STR, 4'h0, "str_f",   E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, STR, 4'h0, "str_d",   E(1,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(1, 1, STR, 4'h0, "str_ma",  E(2,0,0,0,0,0,0,0,0,2'b01,2'b00));
    cyc(1, 0, STR, 4'h0, "str_mw",  E(5,0,0,0,1,1,1,0,0,2'b00,2'b00));
    cyc(0, 0, STR, 4'h0, "str_rst", E(5,0,0,0,0,1,0,0,0,2'b00,2'b00));
    // Op=11 illegal
    cyc(1, 1, OP11, 4'h0, "op11_f", E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, OP11, 4'h0, "op11_d", E(1,0,0,0,0,0,0,0,1,2'b10,2'b00));
    // unsupported DP command illegal
    cyc(1, 1, EOR, 4'h0, "eor_f", E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, EOR, 4'h0, "eor_d", E(1,0,0,0,0,0,0,0,1,2'b10,2'b00));
    // ADD to R15: PC write instead of register write
    cyc(1, 1, ADDPC, 4'h0, "addpc_f",  E(0,1,1,0,0,0,1,0,0,2'b10,2'b00));
    cyc(1, 1, ADDPC, 4'h0, "addpc_d",  E(1,0,0,0,0,0,0,0,0,2'b10,2'b00));
    cyc(1, 1, ADDPC, 4'h0, "addpc_x",  E(6,0,0,0,0,0,0,0,0,2'b00,2'b00));
    cyc(1, 1, ADDPC, 4'h0, "addpc_wb", E(8,1,0,0,0,0,0,1,0,2'b00,2'b00));
    cyc(1, 0, ADDPC, 4'h0, "end_f",    E(0,0,0,0,0,0,1,0,0,2'b10,2'b00));

    // let the monitor drain the scoreboard, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d records left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
